pulse_stretcher: RTL and testbench

//  Output-side counterpart of the button debounce/one-shot stage: turns single-cycle event pulses

---
 rtl/pulse_stretch_pkg.sv | 15 +
 rtl/pulse_stretcher_if.sv | 21 ++
 rtl/pulse_stretcher_cycle_timer.sv | 27 ++
 rtl/pulse_stretcher.sv | 104 ++++++++++
 tb/tb_pulse_stretcher.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pulse_stretch_pkg.sv
// State encodings and default timing for the pulse stretcher (50 MHz: 100 ms high, 50 ms gap).
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_HIGH_CYCLES  = 5000000;
    localparam int DEF_GAP_CYCLES   = 2500000;
    localparam int DEF_COUNTERWIDTH = 32;
    localparam int DEF_QUEUE_WIDTH  = 4;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event strobe in, stretched level plus status out; master drives events, slave is the stretcher.
interface pulse_stretcher_if #(
    parameter int QUEUE_WIDTH = pulse_stretch_pkg::DEF_QUEUE_WIDTH
);
    logic                   pulse_in;
    logic                   clr_overflow;
    logic                   stretch_out;
    logic                   busy;
    logic [QUEUE_WIDTH-1:0] pending;
    logic                   overflow;

    modport master (
        output pulse_in, clr_overflow,
        input  stretch_out, busy, pending, overflow
    );

    modport slave (
        input  pulse_in, clr_overflow,
        output stretch_out, busy, pending, overflow
    );
endinterface

// File: rtl/pulse_stretcher_cycle_timer.sv
// Saturating up-counter with synchronous clear; done is high while count has reached last.
// Shared by the HIGH and GAP phases, so last is switched by the caller per phase.
module cycle_timer #(
    parameter int COUNTERWIDTH = 32
) (
    input  logic                    clk_50MHz,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [COUNTERWIDTH-1:0] last,
    output logic                    done
);

    logic [COUNTERWIDTH-1:0] count;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != last) begin
            count <= count + COUNTERWIDTH'(1);
        end
    end

    assign done = (count == last);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle events into HIGH_CYCLES high + GAP_CYCLES low windows, 1-cycle latency, no backpressure:
// events arriving while busy are queued when STRETCH_QUEUE_EN is defined, otherwise dropped and flagged in overflow.
module pulse_stretcher
    import pulse_stretch_pkg::*;
#(
    parameter int HIGH_CYCLES  = DEF_HIGH_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int COUNTERWIDTH = DEF_COUNTERWIDTH,
    parameter int QUEUE_WIDTH  = DEF_QUEUE_WIDTH
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);

    localparam logic [COUNTERWIDTH-1:0] HIGH_LAST = COUNTERWIDTH'(HIGH_CYCLES - 1);
    localparam logic [COUNTERWIDTH-1:0] GAP_LAST  = COUNTERWIDTH'(GAP_CYCLES - 1);

    state_t                  state_q, state_nxt;
    logic                    stretch_q, stretch_nxt;
    logic                    busy_q, busy_nxt;
    logic                    ovf_q, ovf_nxt;
    logic [QUEUE_WIDTH-1:0]  pending_q;
    logic                    evt, enq, lost, deq;
    logic                    tmr_clr, tmr_done;
    logic [COUNTERWIDTH-1:0] tmr_last;

    assign evt = bus.pulse_in && (state_q != ST_IDLE);

`ifdef STRETCH_QUEUE_EN
    assign enq = evt && (pending_q != '1);

    // A simultaneous enqueue and dequeue leaves the count untouched.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else if (enq && !deq) begin
            pending_q <= pending_q + QUEUE_WIDTH'(1);
        end else if (deq && !enq) begin
            pending_q <= pending_q - QUEUE_WIDTH'(1);
        end
    end
`else
    assign enq       = 1'b0;
    assign pending_q = '0;
`endif

    assign lost = evt && !enq;
    // An event landing on the last gap cycle is consumed at once, so it can start the next window.
    assign deq  = (state_q == ST_GAP) && tmr_done && ((pending_q != '0) || enq);

    assign tmr_last = (state_q == ST_HIGH) ? HIGH_LAST : GAP_LAST;
    assign tmr_clr  = (state_q == ST_IDLE) || tmr_done;

    cycle_timer #(
        .COUNTERWIDTH (COUNTERWIDTH)
    ) u_timer (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .clr       (tmr_clr),
        .last      (tmr_last),
        .done      (tmr_done)
    );

    always_comb begin
        state_nxt   = state_q;
        stretch_nxt = stretch_q;
        busy_nxt    = busy_q;
        ovf_nxt     = ovf_q;
        case (state_q)
            ST_IDLE: if (bus.pulse_in) state_nxt = ST_HIGH;
            ST_HIGH: if (tmr_done)     state_nxt = ST_GAP;
            ST_GAP:  if (tmr_done)     state_nxt = deq ? ST_HIGH : ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
        stretch_nxt = (state_nxt == ST_HIGH);
        busy_nxt    = (state_nxt != ST_IDLE);
        if (lost) begin
            ovf_nxt = 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stretch_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            stretch_q <= stretch_nxt;
            busy_q    <= busy_nxt;
            ovf_q     <= ovf_nxt;
        end
    end

    assign bus.stretch_out = stretch_q;
    assign bus.busy        = busy_q;
    assign bus.pending     = pending_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher; expected per-cycle {stretch,busy,pending,overflow} words are queued then popped each edge.
module tb_pulse_stretcher;

    localparam int HC = 4;
    localparam int GC = 2;
    localparam int QW = 2;
    localparam int CW = 8;

    typedef logic [QW+2:0] obs_t;

    logic clk_50MHz = 1'b0;
    logic rst       = 1'b1;

    pulse_stretcher_if #(.QUEUE_WIDTH(QW)) bus ();

    pulse_stretcher #(
        .HIGH_CYCLES  (HC),
        .GAP_CYCLES   (GC),
        .COUNTERWIDTH (CW),
        .QUEUE_WIDTH  (QW)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bus       (bus)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;

    function automatic obs_t obs();
        return {bus.stretch_out, bus.busy, bus.pending, bus.overflow};
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%b want=%b ({stretch,busy,pending,ovf})", tag, got, want);
        end
    endtask

    task automatic ex(input int n, input int s, input int b, input int p, input int o);
        for (int i = 0; i < n; i++) exp_q.push_back({1'(s), 1'(b), QW'(p), 1'(o)});
    endtask

    task automatic cyc();
        obs_t want;
        @(posedge clk_50MHz);
        #1;
        cyc_n++;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow cyc%0d got=%b want=<none>", cyc_n, obs());
        end else begin
            want = exp_q.pop_front();
            check($sformatf("cyc%0d", cyc_n), obs(), want);
        end
    endtask

    task automatic pcyc();
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) cyc();
    endtask

    task automatic clr_ovf();
        ex(1, 0, 0, 0, 0);
        bus.clr_overflow = 1'b1;
        cyc();
        bus.clr_overflow = 1'b0;
    endtask

    initial begin
        bus.pulse_in     = 1'b0;
        bus.clr_overflow = 1'b0;

        // reset state
        #25;
        check("reset_state", obs(), '0);
        rst = 1'b0;
        ex(2, 0, 0, 0, 0);
        drain();

        // single event: 4 high, 2 gap, then idle
        ex(HC, 1, 1, 0, 0);
        ex(GC, 0, 1, 0, 0);
        ex(1, 0, 0, 0, 0);
        pcyc();
        drain();

        // events at t and t+2
`ifdef STRETCH_QUEUE_EN
        ex(2, 1, 1, 0, 0); ex(2, 1, 1, 1, 0); ex(2, 0, 1, 1, 0);
        ex(4, 1, 1, 0, 0); ex(2, 0, 1, 0, 0); ex(1, 0, 0, 0, 0);
`else
        ex(2, 1, 1, 0, 0); ex(2, 1, 1, 0, 1); ex(2, 0, 1, 0, 1); ex(1, 0, 0, 0, 1);
`endif
        pcyc(); cyc(); pcyc();
        drain();
        clr_ovf();

        // event on the last gap cycle with nothing pending
        ex(HC, 1, 1, 0, 0); ex(GC, 0, 1, 0, 0);
`ifdef STRETCH_QUEUE_EN
        ex(HC, 1, 1, 0, 0); ex(GC, 0, 1, 0, 0); ex(1, 0, 0, 0, 0);
`else
        ex(1, 0, 0, 0, 1);
`endif
        pcyc();
        repeat (HC + GC - 1) cyc();
        pcyc();
        drain();
        clr_ovf();

        // five consecutive events: saturation, and a loss beats clr_overflow
`ifdef STRETCH_QUEUE_EN
        ex(1, 1, 1, 0, 0); ex(1, 1, 1, 1, 0); ex(1, 1, 1, 2, 0); ex(1, 1, 1, 3, 0);
        ex(GC, 0, 1, 3, 1);
        ex(HC, 1, 1, 2, 1); ex(GC, 0, 1, 2, 1);
        ex(HC, 1, 1, 1, 1); ex(GC, 0, 1, 1, 1);
        ex(HC, 1, 1, 0, 1); ex(GC, 0, 1, 0, 1);
        ex(1, 0, 0, 0, 1);
`else
        ex(1, 1, 1, 0, 0); ex(3, 1, 1, 0, 1); ex(GC, 0, 1, 0, 1); ex(1, 0, 0, 0, 1);
`endif
        repeat (4) pcyc();
        bus.pulse_in     = 1'b1;
        bus.clr_overflow = 1'b1;
        cyc();
        bus.pulse_in     = 1'b0;
        bus.clr_overflow = 1'b0;
        drain();
        clr_ovf();

        // event on the last gap cycle while one is already pending
`ifdef STRETCH_QUEUE_EN
        ex(1, 1, 1, 0, 0); ex(3, 1, 1, 1, 0); ex(GC, 0, 1, 1, 0);
        ex(HC, 1, 1, 1, 0); ex(GC, 0, 1, 1, 0);
        ex(HC, 1, 1, 0, 0); ex(GC, 0, 1, 0, 0); ex(1, 0, 0, 0, 0);
`else
        ex(1, 1, 1, 0, 0); ex(3, 1, 1, 0, 1); ex(GC, 0, 1, 0, 1); ex(1, 0, 0, 0, 1);
`endif
        pcyc(); pcyc();
        repeat (HC + GC - 2) cyc();
        pcyc();
        drain();
        clr_ovf();

        // asynchronous reset in the middle of a window
`ifdef STRETCH_QUEUE_EN
        ex(1, 1, 1, 0, 0); ex(1, 1, 1, 1, 0); ex(1, 1, 1, 2, 0);
`else
        ex(1, 1, 1, 0, 0); ex(2, 1, 1, 0, 1);
`endif
        repeat (3) pcyc();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_mid_window", obs(), '0);
        #5;
        rst = 1'b0;
        ex(3 * (HC + GC), 0, 0, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
